ramp_trigger_gen: RTL and testbench

Conditions the external ramp-trigger line and produces the one-cycle `trigger_enable` strobe consumed by the PID block, which latches P, I and D updates on it. The line is synchronised, deglitched and falling-edge detected. The strobe is then placed a programmable delay after the edge. Further edges are ignored for a programmable holdoff, so the PID updates exactly once per ramp period. Sits between the board trigger input pin and the `trigger_enable` input of the PID block, in the same 125 MHz domain.

---
 rtl/ramp_trig_pkg.sv | 31 +++
 rtl/trig_deglitch.sv | 59 +++++
 rtl/ramp_trigger_gen.sv | 208 ++++++++++++++++++++
 tb/tb_ramp_trigger_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramp_trig_pkg.sv
// ramp_trig_pkg: shared types and constants for the ramp trigger generator.
// Holds the FSM state enum, default widths for the delay, holdoff and
// deglitch settings, the idle level of the trigger line, and a saturating
// increment helper for the drop counter.
package ramp_trig_pkg;

  // Default widths of the programmable settings
  localparam int unsigned DLY_W_DEF = 16;
  localparam int unsigned HLD_W_DEF = 20;
  localparam int unsigned DGL_W_DEF = 4;

  // Fixed widths of the statistics and watchdog paths
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DROP_W = 16;

  // The trigger line idles high; the synchroniser and filter reset to it
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    DELAY   = 2'd2,
    HOLDOFF = 2'd3
  } ramp_state_e;

  // Increment that sticks at all-ones
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == '1) ? v : DROP_W'(v + 1'b1);
  endfunction

endpackage

// File: rtl/trig_deglitch.sv
// trig_deglitch: front end of the ramp trigger path.
// Two-flop synchroniser, persistence filter and falling-edge detect.
// Ports:
//   clk      - clock
//   rst_n    - asynchronous active-low reset
//   line     - raw trigger line, asynchronous to clk
//   set_dgl  - deglitch length D; a level change must persist D+1 cycles
//   fall     - one-cycle pulse, cycle after the filtered level drops
module trig_deglitch
  import ramp_trig_pkg::*;
#(
  parameter int unsigned DGL_W = DGL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             line,
  input  logic [DGL_W-1:0] set_dgl,
  output logic             fall
);

  logic             sync_a;
  logic             sync_q;
  logic             filt;
  logic             filt_nxt;
  logic [DGL_W-1:0] dcnt;
  logic [DGL_W-1:0] dcnt_nxt;

  // Filter: count consecutive mismatches, accept the new level once the
  // count has reached D. ">=" keeps a lowered D from stalling the counter.
  always_comb begin
    filt_nxt = filt;
    dcnt_nxt = '0;
    if (sync_q != filt) begin
      if (dcnt >= set_dgl) begin
        filt_nxt = sync_q;
      end else begin
        dcnt_nxt = DGL_W'(dcnt + 1'b1);
      end
    end
  end

  // Registered fall is high exactly when filt_d & ~filt would be
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= LINE_IDLE;
      sync_q <= LINE_IDLE;
      filt   <= LINE_IDLE;
      dcnt   <= '0;
      fall   <= 1'b0;
    end else begin
      sync_a <= line;
      sync_q <= sync_a;
      filt   <= filt_nxt;
      dcnt   <= dcnt_nxt;
      fall   <= filt & ~filt_nxt;
    end
  end

endmodule

// File: rtl/ramp_trigger_gen.sv
// ramp_trigger_gen: conditions the external ramp trigger and issues the
// one-cycle trigger_enable strobe for the PID block, a programmable delay
// after each accepted falling edge, then ignores edges for a holdoff.
// Optional build macro: RAMP_TRIG_WDOG_EN adds the no-strobe watchdog;
// without it wdog_timeout_o is tied low and set_wdog_i is unused.
// Ports:
//   clk, rstn_i        - clock, asynchronous active-low reset
//   ramp_trig_i        - raw trigger line (asynchronous)
//   enable_i           - 1 arms the generator, 0 forces IDLE
//   set_dgl_i          - deglitch length
//   set_delay_i        - cycles from detected edge to strobe
//   set_holdoff_i      - cycles after strobe during which edges are ignored
//   set_wdog_i         - watchdog limit in cycles, 0 disables
//   trigger_enable_o   - one-cycle strobe
//   busy_o             - high in DELAY or HOLDOFF
//   trig_cnt_o         - strobes issued, wrapping
//   drop_cnt_o         - edges ignored, saturating
//   wdog_timeout_o     - sticky watchdog flag
module ramp_trigger_gen
  import ramp_trig_pkg::*;
#(
  parameter int unsigned DLY_W = DLY_W_DEF,
  parameter int unsigned HLD_W = HLD_W_DEF,
  parameter int unsigned DGL_W = DGL_W_DEF
) (
  input  logic              clk,
  input  logic              rstn_i,
  input  logic              ramp_trig_i,
  input  logic              enable_i,
  input  logic [DGL_W-1:0]  set_dgl_i,
  input  logic [DLY_W-1:0]  set_delay_i,
  input  logic [HLD_W-1:0]  set_holdoff_i,
  input  logic [CNT_W-1:0]  set_wdog_i,
  output logic              trigger_enable_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  trig_cnt_o,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              wdog_timeout_o
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_ARMED   = ARMED;
  localparam logic [1:0] S_DELAY   = DELAY;
  localparam logic [1:0] S_HOLDOFF = HOLDOFF;

  logic              fall;
  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DLY_W-1:0]  dly_q;
  logic [DLY_W-1:0]  dly_d;
  logic [HLD_W-1:0]  hld_q;
  logic [HLD_W-1:0]  hld_d;
  logic [HLD_W-1:0]  hsh_q;
  logic [HLD_W-1:0]  hsh_d;
  logic              strobe_c;
  logic              drop_c;
  logic              busy_d;
  logic [CNT_W-1:0]  trig_cnt_d;
  logic [DROP_W-1:0] drop_cnt_d;

  trig_deglitch #(
    .DGL_W (DGL_W)
  ) u_deglitch (
    .clk     (clk),
    .rst_n   (rstn_i),
    .line    (ramp_trig_i),
    .set_dgl (set_dgl_i),
    .fall    (fall)
  );

  // Next state, counters and strobe decision
  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    hld_d      = hld_q;
    hsh_d      = hsh_q;
    strobe_c   = 1'b0;
    drop_c     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_i) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (fall) begin
          // Holdoff is shadowed so later setting changes wait for the next edge
          hsh_d = set_holdoff_i;
          if (set_delay_i == '0) begin
            strobe_c = 1'b1;
            if (set_holdoff_i != '0) begin
              state_d = S_HOLDOFF;
              hld_d   = set_holdoff_i;
            end
          end else begin
            state_d = S_DELAY;
            dly_d   = set_delay_i;
          end
        end
      end
      S_DELAY: begin
        drop_c = fall;
        // Count of 1 means this edge is the delay-th after the accepted fall
        if (dly_q <= DLY_W'(1)) begin
          strobe_c = 1'b1;
          if (hsh_q != '0) begin
            state_d = S_HOLDOFF;
            hld_d   = hsh_q;
          end else begin
            state_d = S_ARMED;
          end
        end else begin
          dly_d = DLY_W'(dly_q - 1'b1);
        end
      end
      S_HOLDOFF: begin
        // An edge on the expiry cycle is still dropped
        drop_c = fall;
        if (hld_q <= HLD_W'(1)) begin
          state_d = S_ARMED;
        end else begin
          hld_d = HLD_W'(hld_q - 1'b1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Disable overrides everything, including a strobe due this cycle
    if (!enable_i) begin
      state_d  = S_IDLE;
      strobe_c = 1'b0;
      drop_c   = 1'b0;
      dly_d    = '0;
      hld_d    = '0;
      hsh_d    = '0;
    end

    trig_cnt_d = trig_cnt_o;
    drop_cnt_d = drop_cnt_o;
    if (!enable_i) begin
      trig_cnt_d = '0;
      drop_cnt_d = '0;
    end else begin
      if (strobe_c) trig_cnt_d = CNT_W'(trig_cnt_o + 1'b1);
      if (drop_c)   drop_cnt_d = sat_inc(drop_cnt_o);
    end

    busy_d = (state_d == S_DELAY) || (state_d == S_HOLDOFF);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q          <= S_IDLE;
      dly_q            <= '0;
      hld_q            <= '0;
      hsh_q            <= '0;
      trigger_enable_o <= 1'b0;
      busy_o           <= 1'b0;
      trig_cnt_o       <= '0;
      drop_cnt_o       <= '0;
    end else begin
      state_q          <= state_d;
      dly_q            <= dly_d;
      hld_q            <= hld_d;
      hsh_q            <= hsh_d;
      trigger_enable_o <= strobe_c;
      busy_o           <= busy_d;
      trig_cnt_o       <= trig_cnt_d;
      drop_cnt_o       <= drop_cnt_d;
    end
  end

`ifdef RAMP_TRIG_WDOG_EN
  logic [CNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0] wcnt_d;
  logic             wdog_d;

  // Cycles since arming or the last strobe; flag sticks once the limit is hit
  always_comb begin
    wcnt_d = wcnt_q;
    wdog_d = wdog_timeout_o;
    if ((state_d == S_IDLE) || strobe_c) begin
      wcnt_d = '0;
      wdog_d = 1'b0;
    end else if (state_q != S_IDLE) begin
      wcnt_d = CNT_W'(wcnt_q + 1'b1);
      if ((set_wdog_i != '0) && (wcnt_d == set_wdog_i)) wdog_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      wcnt_q         <= '0;
      wdog_timeout_o <= 1'b0;
    end else begin
      wcnt_q         <= wcnt_d;
      wdog_timeout_o <= wdog_d;
    end
  end
`else
  logic unused_wdog;
  assign unused_wdog    = ^set_wdog_i;
  assign wdog_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_ramp_trigger_gen.sv
// tb_ramp_trigger_gen: directed and randomized checks of ramp_trigger_gen
// against a time-window reference model (edge acceptance times, strobe
// time = edge + delay, busy window, ignore window).
`timescale 1ns/1ps
module tb_ramp_trigger_gen;

`ifdef RAMP_TRIG_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif
  localparam longint NEVER = 64'sh3FFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rstn;
  logic        line;
  logic        en;
  logic [3:0]  dgl;
  logic [15:0] dly;
  logic [19:0] hld;
  logic [31:0] wdog;
  logic        trig;
  logic        busy;
  logic [31:0] tcnt;
  logic [15:0] dcnt;
  logic        wto;

  always #4 clk = ~clk;

  ramp_trigger_gen dut (
    .clk              (clk),
    .rstn_i           (rstn),
    .ramp_trig_i      (line),
    .enable_i         (en),
    .set_dgl_i        (dgl),
    .set_delay_i      (dly),
    .set_holdoff_i    (hld),
    .set_wdog_i       (wdog),
    .trigger_enable_o (trig),
    .busy_o           (busy),
    .trig_cnt_o       (tcnt),
    .drop_cnt_o       (dcnt),
    .wdog_timeout_o   (wto)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc = 0;
  int          strobes_seen = 0;
  int          busy_seen = 0;
  int          last_strobe = -1;

  // Reference model state
  logic        raw_hist [0:23];
  logic        m_filt;
  logic        m_fall_prev;
  logic        m_active;
  logic        m_strobe;
  longint      armed_from;
  longint      strobe_at;
  longint      busy_lo;
  longint      busy_hi;
  longint      wref;
  logic [31:0] m_trig;
  logic [15:0] m_drop;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 24; k++) raw_hist[k] = 1'b1;
    m_filt      = 1'b1;
    m_fall_prev = 1'b0;
    m_active    = 1'b0;
    m_strobe    = 1'b0;
    armed_from  = NEVER;
    strobe_at   = -1;
    busy_lo     = 0;
    busy_hi     = -1;
    wref        = 0;
    m_trig      = '0;
    m_drop      = '0;
  endtask

  // Advance the model by the clock edge just taken (inputs as sampled there)
  task automatic model_step();
    logic fall_now;
    bit   all_diff;
    for (int k = 23; k > 0; k--) raw_hist[k] = raw_hist[k-1];
    raw_hist[0] = line;
    // Level changes once the last D+1 synchronised samples all disagree with it
    fall_now = 1'b0;
    all_diff = 1'b1;
    for (int k = 0; k <= int'(dgl); k++) if (raw_hist[2+k] == m_filt) all_diff = 1'b0;
    if (all_diff) begin
      m_filt   = ~m_filt;
      fall_now = (m_filt == 1'b0);
    end
    m_strobe = 1'b0;
    if (!en) begin
      m_active   = 1'b0;
      armed_from = NEVER;
      strobe_at  = -1;
      busy_hi    = -1;
      m_trig     = '0;
      m_drop     = '0;
    end else if (!m_active) begin
      m_active   = 1'b1;
      armed_from = longint'(cyc) + 1;
      wref       = longint'(cyc);
    end else begin
      if (m_fall_prev) begin
        if (longint'(cyc) >= armed_from) begin
          strobe_at  = longint'(cyc) + longint'(dly);
          busy_lo    = longint'(cyc);
          busy_hi    = longint'(cyc) + longint'(dly) + longint'(hld) - 1;
          armed_from = longint'(cyc) + longint'(dly) + longint'(hld) + 1;
        end else if (m_drop != 16'hFFFF) begin
          m_drop = m_drop + 16'd1;
        end
      end
      if (strobe_at == longint'(cyc)) begin
        m_strobe = 1'b1;
        m_trig   = m_trig + 32'd1;
        wref     = longint'(cyc);
      end
    end
    m_fall_prev = fall_now;
  endtask

  task automatic compare_all();
    logic exp_busy;
    logic exp_wto;
    exp_busy = (longint'(cyc) >= busy_lo) && (longint'(cyc) <= busy_hi);
    exp_wto  = WDOG_ON && m_active && (wdog != 0) &&
               ((longint'(cyc) - wref) >= longint'(wdog));
    if (trig === 1'b1) begin
      strobes_seen++;
      last_strobe = cyc;
    end
    if (busy === 1'b1) busy_seen++;
    chk("strobe",   32'(trig), 32'(m_strobe));
    chk("busy",     32'(busy), 32'(exp_busy));
    chk("trig_cnt", tcnt, m_trig);
    chk("drop_cnt", 32'(dcnt), 32'(m_drop));
    chk("wdog",     32'(wto), 32'(exp_wto));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (rstn) begin
      model_step();
      compare_all();
    end
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_strobe"}, 32'(trig), 32'd0);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_trig"},   tcnt, 32'd0);
    chk({tag, "_drop"},   32'(dcnt), 32'd0);
    chk({tag, "_wdog"},   32'(wto), 32'd0);
  endtask

  initial begin
    int e0;
    int e1;
    int s0;
    int b0;
    int lo;
    int hi;
    rstn = 1'b0;
    line = 1'b1;
    en   = 1'b0;
    dgl  = 4'd0;
    dly  = 16'd0;
    hld  = 20'd0;
    wdog = 32'd1000;
    model_reset();

    // Reset values
    #2;
    check_zero("reset");
    run(3);
    rstn = 1'b1;
    model_reset();
    run(2);

    // Basic latency, D=0 delay=0 holdoff=0
    en = 1'b1;
    run(5);
    s0 = strobes_seen;
    line = 1'b0;
    e0 = cyc + 1;
    run(4);
    line = 1'b1;
    run(10);
    chk("lat_count", 32'(strobes_seen - s0), 32'd1);
    chk("lat_time", 32'(last_strobe), 32'(e0 + 3));
    chk("lat_trig_cnt", tcnt, 32'd1);

    // Deglitch D=4: 4-cycle pulse rejected, 6-cycle pulse accepted
    dgl = 4'd4;
    run(8);
    s0 = strobes_seen;
    line = 1'b0;
    run(4);
    line = 1'b1;
    run(15);
    chk("dgl_short_count", 32'(strobes_seen - s0), 32'd0);
    chk("dgl_short_drop", 32'(dcnt), 32'd0);
    line = 1'b0;
    e0 = cyc + 1;
    run(6);
    line = 1'b1;
    run(15);
    chk("dgl_long_count", 32'(strobes_seen - s0), 32'd1);
    chk("dgl_long_time", 32'(last_strobe), 32'(e0 + 3 + 4));

    // Delay 10, holdoff 100, edges at t=0, t=50 and t=200
    dgl = 4'd0;
    dly = 16'd10;
    hld = 20'd100;
    run(10);
    s0 = strobes_seen;
    b0 = busy_seen;
    line = 1'b0;
    e0 = cyc + 1;
    run(3);
    line = 1'b1;
    run(47);
    line = 1'b0;
    run(3);
    line = 1'b1;
    run(147);
    chk("dh_count", 32'(strobes_seen - s0), 32'd1);
    chk("dh_time", 32'(last_strobe), 32'(e0 + 13));
    chk("dh_drop", 32'(dcnt), 32'd1);
    chk("dh_busy_len", 32'(busy_seen - b0), 32'd110);
    line = 1'b0;
    e1 = cyc + 1;
    run(3);
    line = 1'b1;
    run(20);
    chk("dh_count2", 32'(strobes_seen - s0), 32'd2);
    chk("dh_time2", 32'(last_strobe), 32'(e1 + 13));

    // Strobe counter wraps
    force dut.trig_cnt_o = 32'hFFFF_FFFF;
    m_trig = 32'hFFFF_FFFF;
    step();
    release dut.trig_cnt_o;
    run(100);
    dly = 16'd0;
    hld = 20'd0;
    line = 1'b0;
    run(3);
    line = 1'b1;
    run(8);
    chk("wrap_trig_cnt", tcnt, 32'd0);

    // Drop counter saturates
    hld = 20'd200;
    force dut.drop_cnt_o = 16'hFFF0;
    m_drop = 16'hFFF0;
    step();
    release dut.drop_cnt_o;
    line = 1'b0;
    run(3);
    line = 1'b1;
    run(3);
    for (int i = 0; i < 20; i++) begin
      line = 1'b0;
      run(2);
      line = 1'b1;
      run(2);
    end
    run(4);
    chk("sat_drop", 32'(dcnt), 32'h0000_FFFF);
    run(150);

    // Abort by enable with 5 delay cycles remaining
    dly = 16'd20;
    hld = 20'd5;
    s0 = strobes_seen;
    line = 1'b0;
    e0 = cyc + 1;
    run(3);
    line = 1'b1;
    run(15);
    en = 1'b0;
    run(1);
    check_zero("abort_en");
    run(10);
    chk("abort_en_count", 32'(strobes_seen - s0), 32'd0);
    en = 1'b1;
    run(5);

    // Abort by asynchronous reset with 5 delay cycles remaining
    s0 = strobes_seen;
    line = 1'b0;
    run(3);
    line = 1'b1;
    run(15);
    #2;
    rstn = 1'b0;
    #1;
    check_zero("abort_rst");
    run(2);
    rstn = 1'b1;
    model_reset();
    run(12);
    chk("abort_rst_count", 32'(strobes_seen - s0), 32'd0);

    // Watchdog: no edges for longer than the limit, then one strobe
    en = 1'b0;
    run(1);
    en = 1'b1;
    dly = 16'd0;
    hld = 20'd0;
    run(1010);
    chk("wdog_gap", 32'(wto), 32'(WDOG_ON));
    line = 1'b0;
    run(3);
    line = 1'b1;
    run(3);
    chk("wdog_cleared", 32'(wto), 32'd0);

    // Randomized bursts
    for (int b = 0; b < 40; b++) begin
      if ((b % 8) == 0) begin
        line = 1'b1;
        run(25);
        dgl = 4'($urandom_range(0, 5));
      end
      dly = 16'($urandom_range(0, 12));
      hld = ($urandom_range(0, 3) == 0) ? 20'd0 : 20'($urandom_range(1, 30));
      for (int p = 0; p < 18; p++) begin
        lo = int'($urandom_range(1, 6));
        hi = int'($urandom_range(1, 12));
        line = 1'b0;
        run(lo);
        line = 1'b1;
        if ($urandom_range(0, 29) == 0) en = 1'b0;
        run(hi);
        en = 1'b1;
        if ($urandom_range(0, 5) == 0) dly = 16'($urandom_range(0, 12));
        if ($urandom_range(0, 5) == 0) hld = 20'($urandom_range(0, 30));
      end
    end
    line = 1'b1;
    run(60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
